ram_port_arbiter: RTL
=====================

// Module: ram_port_arbiter
// PURPOSE
//  Shares one single-clock RAM/FIFO block port (read + write, same clock) between NUM_REQ
//  fabric requesters. Round-robin arbitration with bounded bursts; registered RAM-side
//  outputs; read data returned to the winning requester via a tag pipeline.
//  Sits between user logic and the RAM block wrapper (RCLK = WCLK = clk, FMODE = 0).
// PARAMETERS
//  NUM_REQ    4   number of requesters, 2..8
//  AW         11  address width (matches RAM block RADDR/WADDR)
//  DW         32  data width (matches RAM block WDATA/RDATA)
//  RD_LAT     1   RAM read latency in cycles, ram_ren to ram_rdata valid, 1..2
//  BURST_MAX  4   maximum consecutive grants to one requester while others wait, 1..15
// PORTS
//  clk        in   1             clock for all logic and the RAM port
//  rst        in   1             synchronous reset, active-high
//  req        in   NUM_REQ       per-requester request, held until gnt
//  we         in   NUM_REQ       per-requester 1 = write, 0 = read
//  addr       in   NUM_REQ*AW    per-requester address, slice i = [i*AW +: AW]
//  wdata      in   NUM_REQ*DW    per-requester write data
//  gnt        out  NUM_REQ       one-hot grant, combinational, request accepted this cycle
//  rvalid     out  NUM_REQ       one-hot read-data-valid strobe
//  rdata      out  DW            read data, broadcast, qualified by rvalid
//  ram_wen    out  1             RAM write enable, active-high (wrapper adapts polarity)
//  ram_ren    out  1             RAM read enable, active-high
//  ram_waddr  out  AW            RAM write address
//  ram_raddr  out  AW            RAM read address
//  ram_wdata  out  DW            RAM write data
//  ram_rdata  in   DW            RAM read data
//  busy       out  1             any read in flight, or any req asserted
// BEHAVIOUR
//  - Reset: gnt = 0, rvalid = 0, rdata = 0, ram_wen = ram_ren = 0, ram addrs/wdata = 0,
//    priority pointer = 0, burst count = 0, FSM = IDLE, tag pipeline cleared.
//    Reads in flight at reset are dropped; no rvalid for them.
//  - At most one gnt bit per cycle. gnt[i] is only raised if req[i] is high.
//    A granted request is consumed that cycle.
//  - FSM IDLE: no owner. If any req is high, grant the first requester at or after the
//    pointer, in round-robin order. Move to OWN(i) with burst count = 1.
//  - FSM OWN(i):
//    - If req[i] is high and (count < BURST_MAX or no other req is high): grant i again
//      and increment count (saturating at BURST_MAX).
//    - Else if another req is high: grant the next requester after i in round-robin
//      order. Owner becomes that requester, count = 1, pointer = owner + 1 mod NUM_REQ.
//    - Else (no req): go to IDLE and set pointer = i + 1 mod NUM_REQ.
//  - Write grant: in the next cycle, ram_wen = 1 and ram_waddr/ram_wdata hold the
//    granted slices. Read grant: in the next cycle, ram_ren = 1 and ram_raddr holds the
//    granted address. Both enables are low in cycles with no grant.
//  - Read return: the requester index is carried through a tag pipeline. rvalid[idx]
//    and rdata are registered and appear exactly 1 + RD_LAT + 1 cycles after gnt.
//    With RD_LAT = 1 this is 3 cycles. Back-to-back reads are fully pipelined, one
//    per cycle.
//  - Write followed by a read to the same address on the next grant returns the new
//    data. This relies on the RAM block having no write-to-read hazard across cycles;
//    the arbiter inserts no bubble.
//  - rdata holds its last value when rvalid = 0.
//  - A dropped req (req[i] falls without a grant) is legal. An owner whose req falls
//    loses ownership as above.
// STRUCTURE
//  - Shared package ram_arb_pkg:
//    - FSM state enum (ST_IDLE, ST_OWN)
//    - localparam function clog2 for the tag and pointer widths
//    - IDX_W = clog2(NUM_REQ)
//  - Sub-module rr_pick: combinational. Inputs are a request vector and a start pointer;
//    outputs are a one-hot pick and its index. Instantiated once; the FSM muxes its
//    start pointer (pointer in IDLE, owner + 1 when switching).
//  - Top level holds the FSM, burst counter, RAM output registers, the tag pipeline of
//    depth 1 + RD_LAT, and the rdata/rvalid registers.
// TESTING
//  1 Reset mid-burst: NUM_REQ=4, req=4'b0001 reads for 2 cycles, assert rst for 1 cycle
//    -> all outputs 0 the cycle after, no rvalid ever for the two reads.
//  2 Single write then read: req0 writes addr 0x005 data 0xDEADBEEF, then reads 0x005
//    -> ram_wen=1 at gnt+1; rvalid[0]=1 with rdata=0xDEADBEEF 3 cycles after the read gnt.
//  3 Burst limit: req0 and req1 held high continuously, BURST_MAX=4
//    -> gnt pattern 0,0,0,0,1,1,1,1,0,... ; never more than 4 consecutive to one.
//  4 Lone owner exceeds burst: only req2 held for 10 cycles -> gnt[2] on all 10 cycles.
//  5 Round-robin fairness: all 4 reqs high with BURST_MAX=1
//    -> gnt sequence 0,1,2,3,0,...; pointer honoured after IDLE
//    (req3 only, then all -> next grant is 0).
//  6 Pipelined reads: req1 issues 8 back-to-back reads, addrs 0..7, preloaded with
//    value = addr*3 -> rvalid[1] high 8 consecutive cycles, rdata 0,3,6,...,21 in order.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM port arbiter slice.
package ram_arb_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_OWN
  } state_e;

  // Ceiling log2 with a floor of 1 so a 2-requester build still gets a 1-bit index.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after the start index, wrapping.
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          found
);

  always_comb begin
    int unsigned j;
    logic [IW-1:0] jj;
    pick  = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      j  = (32'(start) + k) % N;
      jj = IW'(j);
      if (!found && req[jj]) begin
        found    = 1'b1;
        pick[jj] = 1'b1;
        idx      = jj;
      end
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin, burst-bounded arbiter sharing one RAM read/write port among requesters.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned AW        = 11,
  parameter int unsigned DW        = 32,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req,
  input  logic [NUM_REQ-1:0]    we,
  input  logic [NUM_REQ*AW-1:0] addr,
  input  logic [NUM_REQ*DW-1:0] wdata,
  output logic [NUM_REQ-1:0]    gnt,
  output logic [NUM_REQ-1:0]    rvalid,
  output logic [DW-1:0]         rdata,
  output logic                  ram_wen,
  output logic                  ram_ren,
  output logic [AW-1:0]         ram_waddr,
  output logic [AW-1:0]         ram_raddr,
  output logic [DW-1:0]         ram_wdata,
  input  logic [DW-1:0]         ram_rdata,
  output logic                  busy
);

  localparam int unsigned IDX_W = clog2(NUM_REQ);
  localparam int unsigned CW    = 4;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
  endfunction

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               grant_v;
  logic               grant_from_pick;
  logic [IDX_W-1:0]   grant_idx;

  logic [NUM_REQ-1:0] owner_oh;
  logic [NUM_REQ-1:0] others;
  logic [NUM_REQ-1:0] pick_req;
  logic [IDX_W-1:0]   pick_start;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;

  logic               sel_we;
  logic [AW-1:0]      sel_addr;
  logic [DW-1:0]      sel_wdata;

  logic [RD_LAT:0]             tag_vld;
  logic [RD_LAT:0][IDX_W-1:0]  tag_idx;

  assign owner_oh = NUM_REQ'(1) << owner_q;
  assign others   = req & ~owner_oh;

  // One shared picker: IDLE scans from the pointer, a handover scans from owner+1.
  always_comb begin
    pick_req   = req;
    pick_start = ptr_q;
    if (state_q == ST_OWN) begin
      pick_req   = others;
      pick_start = next_idx(owner_q);
    end
  end

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IDX_W)
  ) u_rr_pick (
    .req   (pick_req),
    .start (pick_start),
    .pick  (pick_oh),
    .idx   (pick_idx),
    .found (pick_found)
  );

  // Next-state logic
  always_comb begin
    state_d         = state_q;
    owner_d         = owner_q;
    ptr_d           = ptr_q;
    cnt_d           = cnt_q;
    grant_v         = 1'b0;
    grant_from_pick = 1'b0;
    grant_idx       = owner_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_v         = 1'b1;
          grant_from_pick = 1'b1;
          grant_idx       = pick_idx;
          owner_d         = pick_idx;
          cnt_d           = CW'(1);
          state_d         = ST_OWN;
        end
      end
      ST_OWN: begin
        if (req[owner_q] && ((cnt_q < CW'(BURST_MAX)) || !(|others))) begin
          grant_v   = 1'b1;
          grant_idx = owner_q;
          if (cnt_q < CW'(BURST_MAX)) cnt_d = cnt_q + 1'b1;
        end else if (pick_found) begin
          grant_v         = 1'b1;
          grant_from_pick = 1'b1;
          grant_idx       = pick_idx;
          owner_d         = pick_idx;
          cnt_d           = CW'(1);
          ptr_d           = next_idx(pick_idx);
        end else begin
          state_d = ST_IDLE;
          ptr_d   = next_idx(owner_q);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    gnt = '0;
    if (grant_v) gnt = grant_from_pick ? pick_oh : owner_oh;
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_we    = we[i];
        sel_addr  = addr[i*AW +: AW];
        sel_wdata = wdata[i*DW +: DW];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // RAM port registers, tag pipeline and read-return registers
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_wen   <= 1'b0;
      ram_ren   <= 1'b0;
      ram_waddr <= '0;
      ram_raddr <= '0;
      ram_wdata <= '0;
      tag_vld   <= '0;
      tag_idx   <= '0;
      rvalid    <= '0;
      rdata     <= '0;
    end else begin
      ram_wen <= grant_v & sel_we;
      ram_ren <= grant_v & ~sel_we;
      if (grant_v && sel_we) begin
        ram_waddr <= sel_addr;
        ram_wdata <= sel_wdata;
      end
      if (grant_v && !sel_we) ram_raddr <= sel_addr;
      tag_vld <= {tag_vld[RD_LAT-1:0], grant_v & ~sel_we};
      tag_idx <= {tag_idx[RD_LAT-1:0], grant_idx};
      rvalid  <= tag_vld[RD_LAT] ? (NUM_REQ'(1) << tag_idx[RD_LAT]) : '0;
      if (tag_vld[RD_LAT]) rdata <= ram_rdata;
    end
  end

  assign busy = (|req) | (|tag_vld);

endmodule
